// File: rtl/chase_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chase_dir_ctrl
// Brief    : Time-multiplexed chase-direction engine for N_CH chasers.
//            Build option CHASE_LFSR_EN: blocked-turn sign taken from an LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module chase_dir_ctrl #(
    parameter int XW         = 11,
    parameter int YW         = 10,
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 1000000,
    parameter int DEADZONE   = 4,
    parameter int HOLD_TICKS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [XW-1:0]        target_x,
    input  logic [YW-1:0]        target_y,
    input  logic [N_CH*XW-1:0]   chaser_x,
    input  logic [N_CH*YW-1:0]   chaser_y,
    input  logic [N_CH-1:0]      blocked,
    output logic [2*N_CH-1:0]    dir,
    output logic [N_CH-1:0]      dir_valid,
    output logic                 busy
);

    localparam int c_W  = ((XW > YW) ? XW : YW) + 1;
    localparam int c_PW = $clog2(TICK_DIV);
    localparam int c_IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_DIV - 1);
    localparam logic [c_IW-1:0] c_LAST_CH   = c_IW'(N_CH - 1);
    localparam logic [c_W:0]    c_DZ        = (c_W + 1)'(DEADZONE);
    localparam logic [c_HW-1:0] c_HOLD      = c_HW'(HOLD_TICKS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [c_PW-1:0]   r_pre;
    logic [c_IW-1:0]   r_idx;
    logic [c_IW-1:0]   w_idx_nx;
    logic              r_pend;
    logic              w_pend_nx;
    logic              w_tick;
    logic              w_eval;

    logic [2*N_CH-1:0] w_dir_all;
    logic [N_CH-1:0]   w_valid_all;
    logic [N_CH-1:0]   w_held_all;

    logic [XW-1:0]     w_cx;
    logic [YW-1:0]     w_cy;
    logic              w_blk;
    logic [1:0]        w_cur_dir;
    logic              w_cur_held;

    logic [c_W-1:0]    w_cxe, w_cye, w_txe, w_tye;
    logic [c_W-1:0]    w_dx, w_dy;
    logic              w_x_dom, w_y_dom, w_x_dec, w_y_dec;
    logic              w_prev_x, w_use_x, w_blk_inc;
    logic [1:0]        w_track_dir, w_blk_dir, w_new_dir;

    // ------------------------------------------------------------------------
    // Decision-tick prescaler
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= (r_pre == c_TICK_LAST) ? '0 : r_pre + c_PW'(1);
        end
    end

    assign w_tick = en && (r_pre == c_TICK_LAST);

    // ------------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_pend  <= w_pend_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_pend_nx  = r_pend;
        w_eval     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pend_nx = 1'b0;
                if (w_tick) begin
                    w_state_nx = S_SCAN;
                    w_idx_nx   = '0;
                end
            end
            S_SCAN: begin
                w_eval = 1'b1;
                if (r_idx == c_LAST_CH) begin
                    w_idx_nx = '0;
                    // A tick landing on the final slot is treated like a pending one.
                    if (r_pend || w_tick) begin
                        w_state_nx = S_SCAN;
                        w_pend_nx  = 1'b0;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_idx_nx = r_idx + c_IW'(1);
                    if (w_tick) begin
                        w_pend_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_idx_nx   = '0;
                w_pend_nx  = 1'b0;
            end
        endcase
        if (!en) begin
            w_pend_nx = 1'b0;
        end
    end

    assign busy = (r_state == S_SCAN);

    // ------------------------------------------------------------------------
    // Channel select and shared evaluator
    // ------------------------------------------------------------------------
    always_comb begin
        w_cx       = '0;
        w_cy       = '0;
        w_blk      = 1'b0;
        w_cur_dir  = 2'd0;
        w_cur_held = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_idx == c_IW'(i)) begin
                w_cx       = chaser_x[i*XW +: XW];
                w_cy       = chaser_y[i*YW +: YW];
                w_blk      = blocked[i];
                w_cur_dir  = w_dir_all[2*i +: 2];
                w_cur_held = w_held_all[i];
            end
        end
    end

    assign w_cxe   = c_W'(w_cx);
    assign w_cye   = c_W'(w_cy);
    assign w_txe   = c_W'(target_x);
    assign w_tye   = c_W'(target_y);
    assign w_dx    = (w_cxe >= w_txe) ? (w_cxe - w_txe) : (w_txe - w_cxe);
    assign w_dy    = (w_cye >= w_tye) ? (w_cye - w_tye) : (w_tye - w_cye);
    assign w_x_dom = {1'b0, w_dx} > ({1'b0, w_dy} + c_DZ);
    assign w_y_dom = {1'b0, w_dy} > ({1'b0, w_dx} + c_DZ);
    assign w_x_dec = w_cxe > w_txe;
    assign w_y_dec = w_cye > w_tye;
    assign w_prev_x = w_cur_dir[1];

    always_comb begin
        w_use_x = w_prev_x;
        if (w_x_dom) begin
            w_use_x = 1'b1;
        end else if (w_y_dom) begin
            w_use_x = 1'b0;
        end else if (w_prev_x && (w_dx == '0)) begin
            w_use_x = 1'b0;
        end else if (!w_prev_x && (w_dy == '0)) begin
            w_use_x = 1'b1;
        end
    end

    // Direction code bit 1 selects the x axis, bit 0 means increase.
    assign w_track_dir = w_use_x ? {1'b1, ~w_x_dec} : {1'b0, ~w_y_dec};

`ifdef CHASE_LFSR_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end

    assign w_blk_inc = r_lfsr[0];
`else
    assign w_blk_inc = w_prev_x ? ~w_y_dec : ~w_x_dec;
`endif

    assign w_blk_dir = {~w_prev_x, w_blk_inc};

    always_comb begin
        w_new_dir = w_track_dir;
        if (w_blk) begin
            w_new_dir = w_blk_dir;
        end else if ((w_dx == '0) && (w_dy == '0)) begin
            w_new_dir = w_cur_dir;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel direction / hold state
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [1:0]      r_dir;
        logic [c_HW-1:0] r_hold;
        logic            r_valid;
        logic            w_sel;

        assign w_sel = w_eval && (r_idx == c_IW'(g));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_dir   <= 2'd0;
                r_hold  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= 1'b0;
                if (w_sel) begin
                    if (w_cur_held) begin
                        r_hold <= r_hold - c_HW'(1);
                    end else begin
                        r_valid <= 1'b1;
                        r_dir   <= w_new_dir;
                        if (w_blk) begin
                            r_hold <= c_HOLD;
                        end
                    end
                end
            end
        end

        assign w_dir_all[2*g +: 2] = r_dir;
        assign w_valid_all[g]      = r_valid;
        assign w_held_all[g]       = (r_hold != '0);
    end

    assign dir       = w_dir_all;
    assign dir_valid = w_valid_all;

endmodule
`default_nettype wire
